// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receiver FSM state encoding and frame constants,
// imported by both the receive and transmit sides of the link.
package uart_receiver_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_e;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_tick.sv
// Free-running oversample tick generator: one-cycle tick every DIV clocks.
module uart_rx_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CW'(DIV - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchronises Rx_in, oversamples each bit at its centre
// and delivers 8E1 frames with a one-cycle valid pulse and parity/framing flags.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx_in,
  output logic [DATA_BITS-1:0] Rx_data,
  output logic                 Rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 Rx_busy
);

  localparam int unsigned DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned BCNT_W = $clog2(DATA_BITS);

  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_BITS - 1);

  logic tick;
  logic sync1_q, sync2_q, rx_s;

  rx_state_e              state_q, state_d;
  logic [SCNT_W-1:0]      scnt_q, scnt_d;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   valid_q, valid_d;

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rx_s = sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Rx_in;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    if (tick) begin
      case (state_q)
        RX_IDLE: begin
          if (rx_s == START_BIT) begin
            state_d = RX_START;
            scnt_d  = '0;
          end
        end
        RX_START: begin
          // Half-bit check rejects glitches shorter than half a bit period
          if (scnt_q == SCNT_HALF) begin
            if (rx_s == START_BIT) begin
              state_d = RX_DATA;
              scnt_d  = '0;
              bcnt_d  = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        RX_DATA: begin
          if (scnt_q == SCNT_LAST) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            scnt_d  = '0;
            bcnt_d  = bcnt_q + BCNT_W'(1);
            if (bcnt_q == BCNT_LAST) state_d = RX_PARITY;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        RX_PARITY: begin
          if (scnt_q == SCNT_LAST) begin
            par_d   = rx_s;
            scnt_d  = '0;
            state_d = RX_STOP;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        RX_STOP: begin
          // Leave at the stop-bit centre so an immediately following start bit is caught
          if (scnt_q == SCNT_LAST) begin
            data_d  = shreg_q;
            perr_d  = (par_q != ^shreg_q);
            ferr_d  = (rx_s != STOP_BIT);
            valid_d = 1'b1;
            scnt_d  = '0;
            state_d = (rx_s == STOP_BIT) ? RX_IDLE : RX_BREAK;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
        RX_BREAK: begin
          if (rx_s == STOP_BIT) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RX_IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
    end
  end

  assign Rx_data    = data_q;
  assign Rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign Rx_busy    = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: drives serial frames bit by bit and
// compares delivered bytes/flags against expectations derived from the frame.
module tb_uart_receiver;

  localparam int BIT_CLKS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx_in = 1'b1;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       Rx_busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_data[$];
  logic       got_perr[$];
  logic       got_ferr[$];
  logic       busy_seen = 1'b0;

  uart_receiver #(.CLK_FREQ(64), .BAUD(1), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rx_in      (Rx_in),
    .Rx_data    (Rx_data),
    .Rx_valid   (Rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .Rx_busy    (Rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (Rx_valid) begin
      got_data.push_back(Rx_data);
      got_perr.push_back(parity_err);
      got_ferr.push_back(frame_err);
    end
    if (Rx_busy) busy_seen = 1'b1;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first, parity, stop; line is left at the stop level.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      Rx_in = bits[i];
      repeat (BIT_CLKS - 1) @(posedge clk);
    end
  endtask

  task automatic clear_capture();
    got_data.delete();
    got_perr.delete();
    got_ferr.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    Rx_in = 1'b1;
    wait_clks(5);
    n_checks += 5;
    if (Rx_data !== 8'h00)  begin n_errors++; $display("FAIL reset_data got %h exp 00", Rx_data); end
    if (Rx_valid !== 1'b0)  begin n_errors++; $display("FAIL reset_valid got %b exp 0", Rx_valid); end
    if (parity_err !== 1'b0) begin n_errors++; $display("FAIL reset_perr got %b exp 0", parity_err); end
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    if (Rx_busy !== 1'b0)   begin n_errors++; $display("FAIL reset_busy got %b exp 0", Rx_busy); end
    rst = 1'b1;
    wait_clks(2 * BIT_CLKS);
  endtask

  task automatic test_basic_frame();
    clear_capture();
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_clks(16);
    n_checks++;
    if (got_data.size() != 1) begin
      n_errors++; $display("FAIL a5_count got %0d exp 1", got_data.size());
    end else begin
      n_checks += 3;
      if (got_data[0] !== 8'hA5) begin n_errors++; $display("FAIL a5_data got %h exp a5", got_data[0]); end
      if (got_perr[0] !== 1'b0)  begin n_errors++; $display("FAIL a5_perr got %b exp 0", got_perr[0]); end
      if (got_ferr[0] !== 1'b0)  begin n_errors++; $display("FAIL a5_ferr got %b exp 0", got_ferr[0]); end
    end
  endtask

  task automatic test_parity_error();
    clear_capture();
    send_frame(8'h01, 1'b0, 1'b1);
    wait_clks(16);
    n_checks++;
    if (got_data.size() != 1) begin
      n_errors++; $display("FAIL par_count got %0d exp 1", got_data.size());
    end else begin
      n_checks += 3;
      if (got_data[0] !== 8'h01) begin n_errors++; $display("FAIL par_data got %h exp 01", got_data[0]); end
      if (got_perr[0] !== 1'b1)  begin n_errors++; $display("FAIL par_perr got %b exp 1", got_perr[0]); end
      if (got_ferr[0] !== 1'b0)  begin n_errors++; $display("FAIL par_ferr got %b exp 0", got_ferr[0]); end
    end
    n_checks++;
    if (parity_err !== 1'b1) begin n_errors++; $display("FAIL par_held got %b exp 1", parity_err); end
  endtask

  task automatic test_break();
    clear_capture();
    send_frame(8'h3C, 1'b0, 1'b0);
    Rx_in = 1'b0;
    wait_clks(BIT_CLKS);
    n_checks++;
    if (Rx_busy !== 1'b1) begin n_errors++; $display("FAIL brk_busy_low got %b exp 1", Rx_busy); end
    Rx_in = 1'b1;
    wait_clks(2 * BIT_CLKS);
    n_checks += 2;
    if (Rx_busy !== 1'b0) begin n_errors++; $display("FAIL brk_busy_idle got %b exp 0", Rx_busy); end
    if (got_data.size() != 1) begin
      n_errors++; $display("FAIL brk_count got %0d exp 1", got_data.size());
    end else begin
      n_checks += 3;
      if (got_data[0] !== 8'h3C) begin n_errors++; $display("FAIL brk_data got %h exp 3c", got_data[0]); end
      if (got_perr[0] !== 1'b0)  begin n_errors++; $display("FAIL brk_perr got %b exp 0", got_perr[0]); end
      if (got_ferr[0] !== 1'b1)  begin n_errors++; $display("FAIL brk_ferr got %b exp 1", got_ferr[0]); end
    end
  endtask

  task automatic test_glitch();
    clear_capture();
    wait_clks(4);
    busy_seen = 1'b0;
    @(posedge clk);
    Rx_in = 1'b0;
    repeat (12) @(posedge clk);
    Rx_in = 1'b1;
    wait_clks(3 * BIT_CLKS);
    n_checks += 3;
    if (busy_seen !== 1'b1)   begin n_errors++; $display("FAIL glitch_busy_pulse got %b exp 1", busy_seen); end
    if (got_data.size() != 0) begin n_errors++; $display("FAIL glitch_valid got %0d exp 0", got_data.size()); end
    if (Rx_busy !== 1'b0)     begin n_errors++; $display("FAIL glitch_idle got %b exp 0", Rx_busy); end
  endtask

  task automatic test_back_to_back();
    clear_capture();
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_clks(16);
    n_checks++;
    if (got_data.size() != 2) begin
      n_errors++; $display("FAIL b2b_count got %0d exp 2", got_data.size());
    end else begin
      n_checks += 4;
      if (got_data[0] !== 8'h00) begin n_errors++; $display("FAIL b2b_data0 got %h exp 00", got_data[0]); end
      if (got_data[1] !== 8'hFF) begin n_errors++; $display("FAIL b2b_data1 got %h exp ff", got_data[1]); end
      if ((got_perr[0] | got_perr[1]) !== 1'b0) begin
        n_errors++; $display("FAIL b2b_perr got %b%b exp 00", got_perr[0], got_perr[1]);
      end
      if ((got_ferr[0] | got_ferr[1]) !== 1'b0) begin
        n_errors++; $display("FAIL b2b_ferr got %b%b exp 00", got_ferr[0], got_ferr[1]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] partial;
    partial = {1'b0, 4'b0011, 1'b0};
    clear_capture();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      Rx_in = partial[i];
      repeat (BIT_CLKS - 1) @(posedge clk);
    end
    // Now mid-way through data bit 4
    @(posedge clk);
    rst = 1'b0;
    wait_clks(3);
    n_checks += 5;
    if (Rx_data !== 8'h00)   begin n_errors++; $display("FAIL rstmid_data got %h exp 00", Rx_data); end
    if (Rx_valid !== 1'b0)   begin n_errors++; $display("FAIL rstmid_valid got %b exp 0", Rx_valid); end
    if (parity_err !== 1'b0) begin n_errors++; $display("FAIL rstmid_perr got %b exp 0", parity_err); end
    if (frame_err !== 1'b0)  begin n_errors++; $display("FAIL rstmid_ferr got %b exp 0", frame_err); end
    if (Rx_busy !== 1'b0)    begin n_errors++; $display("FAIL rstmid_busy got %b exp 0", Rx_busy); end
    Rx_in = 1'b1;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(8 * BIT_CLKS);
    n_checks++;
    if (got_data.size() != 0) begin n_errors++; $display("FAIL rstmid_spurious got %0d exp 0", got_data.size()); end
    send_frame(8'h5A, 1'b0, 1'b1);
    wait_clks(16);
    n_checks++;
    if (got_data.size() != 1) begin
      n_errors++; $display("FAIL rstmid_count got %0d exp 1", got_data.size());
    end else begin
      n_checks += 3;
      if (got_data[0] !== 8'h5A) begin n_errors++; $display("FAIL rstmid_5a got %h exp 5a", got_data[0]); end
      if (got_perr[0] !== 1'b0)  begin n_errors++; $display("FAIL rstmid_5a_perr got %b exp 0", got_perr[0]); end
      if (got_ferr[0] !== 1'b0)  begin n_errors++; $display("FAIL rstmid_5a_ferr got %b exp 0", got_ferr[0]); end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] exp_data[$];
    logic       exp_perr[$];
    logic       exp_ferr[$];
    logic [7:0] d;
    logic       bad_par, bad_stop;
    clear_capture();
    for (int i = 0; i < 12; i++) begin
      d        = 8'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 4) == 0);
      // Reference: even parity bit is the XOR of the data, flipped to inject an error
      send_frame(d, (^d) ^ bad_par, ~bad_stop);
      Rx_in = 1'b1;
      wait_clks(BIT_CLKS);
      exp_data.push_back(d);
      exp_perr.push_back(bad_par);
      exp_ferr.push_back(bad_stop);
    end
    n_checks++;
    if (got_data.size() != exp_data.size()) begin
      n_errors++; $display("FAIL rand_count got %0d exp %0d", got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        n_checks += 3;
        if (got_data[i] !== exp_data[i]) begin
          n_errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, got_data[i], exp_data[i]);
        end
        if (got_perr[i] !== exp_perr[i]) begin
          n_errors++; $display("FAIL rand_perr[%0d] got %b exp %b", i, got_perr[i], exp_perr[i]);
        end
        if (got_ferr[i] !== exp_ferr[i]) begin
          n_errors++; $display("FAIL rand_ferr[%0d] got %b exp %b", i, got_ferr[i], exp_ferr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_parity_error();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
